mul_accum_stage: RTL

//  Downstream consumer of the 32x32 signed shift-add multiplier. Accepts a programmed number of
//  64-bit signed products over a valid/ready handshake and sums them into a wide accumulator.

---
 rtl/mul_accum_pkg.sv | 17 +
 rtl/mul_accum_sat_add.sv | 32 +++
 rtl/mul_accum_stage.sv | 95 +++++++++
 3 files changed

// File: rtl/mul_accum_pkg.sv
// Shared types and default widths for the accumulate stage of the sequential MAC datapath.
package mul_accum_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int unsigned PW_DEF    = 64;
  localparam int unsigned AW_DEF    = 72;
  localparam int unsigned CNT_W_DEF = 8;

  localparam logic [AW_DEF-1:0] ACC_MAX = {1'b0, {(AW_DEF-1){1'b1}}};
  localparam logic [AW_DEF-1:0] ACC_MIN = {1'b1, {(AW_DEF-1){1'b0}}};

endpackage

// File: rtl/mul_accum_sat_add.sv
// AW-bit signed adder with overflow detect; clamps on overflow when ACCUM_SAT_EN is defined.
module mul_accum_sat_add
  import mul_accum_pkg::*;
#(
  parameter int unsigned AW = AW_DEF
) (
  input  logic [AW-1:0] a,
  input  logic [AW-1:0] b,
  output logic [AW-1:0] sum,
  output logic          ovf
);

  logic [AW:0] full;

`ifdef ACCUM_SAT_EN
  localparam logic [AW-1:0] SAT_MAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic [AW-1:0] SAT_MIN = {1'b1, {(AW-1){1'b0}}};
`endif

  always_comb begin
    full = {a[AW-1], a} + {b[AW-1], b};
    ovf  = full[AW] ^ full[AW-1];
`ifdef ACCUM_SAT_EN
    // The extra top bit holds the sign of the true sum, which picks the clamp direction.
    if (ovf) sum = full[AW] ? SAT_MIN : SAT_MAX;
    else     sum = full[AW-1:0];
`else
    sum = full[AW-1:0];
`endif
  end

endmodule

// File: rtl/mul_accum_stage.sv
// Accumulates a programmed number of signed products into a wide sum with a sticky overflow flag.
// Optional saturation on overflow: define ACCUM_SAT_EN.
module mul_accum_stage
  import mul_accum_pkg::*;
#(
  parameter int unsigned PW    = PW_DEF,
  parameter int unsigned AW    = AW_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PW-1:0]    in_p,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [AW-1:0]    out_sum,
  output logic             out_ovf,
  output logic             busy
);

  state_t           state_q, state_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic [AW-1:0]    p_ext;
  logic [AW-1:0]    add_sum;
  logic             add_ovf;

  assign p_ext = AW'($signed(in_p));

  mul_accum_sat_add #(.AW(AW)) u_add (
    .a   (acc_q),
    .b   (p_ext),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d = '0;
          ovf_d = 1'b0;
          if (len != '0) begin
            cnt_d   = len;
            state_d = ACCUM;
          end else begin
            state_d = DONE;
          end
        end
      end
      ACCUM: begin
        if (in_valid) begin
          acc_d = add_sum;
          ovf_d = ovf_q | add_ovf;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_sum   = acc_q;
  assign out_ovf   = ovf_q;

endmodule
